// File: rtl/gram_crg_pkg.sv
// gram_crg_pkg: default power-up sequencing constants and width helper for gram_crg
package gram_crg_pkg;
  localparam int SYNC_RST_CYCLES_DEF = 16;
  localparam int DRAM_RESET_CYCLES_DEF = 20000;
  localparam int DRAM_CKE_CYCLES_DEF = 50000;
  localparam int DRAMSYNC_RST_CYCLES_DEF = 65536;
  function automatic int clog2(input longint v);
    int r = 0;
    for (longint x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction
  localparam int CNT_WIDTH_DEF = clog2(longint'(DRAMSYNC_RST_CYCLES_DEF) + 1);
endpackage

// File: rtl/gram_crg_if.sv
// gram_crg_if: generated domain clocks/resets and DDR3 power-up pin drives
interface gram_crg_if;
  logic crg_sync_clk;
  logic crg_sync_rst;
  logic crg_dramsync_clk;
  logic crg_dramsync_rst;
  logic dram_reset_n;
  logic dram_cke;
  logic init_done;
  modport master (output crg_sync_clk, crg_sync_rst, crg_dramsync_clk, crg_dramsync_rst, dram_reset_n, dram_cke, init_done);
  modport slave (input crg_sync_clk, crg_sync_rst, crg_dramsync_clk, crg_dramsync_rst, dram_reset_n, dram_cke, init_done);
endinterface

// File: rtl/gram_crg_reset_sync.sv
// crg_reset_sync: 2-flop async-assert/sync-deassert reset synchronizer
module crg_reset_sync (
  input  logic clk,
  input  logic arst,
  output logic rst_sync
);
  logic [1:0] rel;
  always_ff @(posedge clk or posedge arst)
    if (arst) rel <= '0;
    else rel <= {rel[0], 1'b1};
  assign rst_sync = ~rel[1];
endmodule

// File: rtl/gram_crg.sv
// gram_crg: board clock passthrough and counter-sequenced resets for sync/dramsync and DDR3 pins
module gram_crg
  import gram_crg_pkg::*;
#(
  parameter int SYNC_RST_CYCLES = SYNC_RST_CYCLES_DEF,
  parameter int DRAM_RESET_CYCLES = DRAM_RESET_CYCLES_DEF,
  parameter int DRAM_CKE_CYCLES = DRAM_CKE_CYCLES_DEF,
  parameter int DRAMSYNC_RST_CYCLES = DRAMSYNC_RST_CYCLES_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input logic clk100_0__io,
  input logic rst_0__io,
  gram_crg_if.master crg
);
  localparam int NEED_W = clog2(longint'(DRAMSYNC_RST_CYCLES) + 1);
  localparam int CW = (CNT_WIDTH < NEED_W) ? NEED_W : CNT_WIDTH;
  localparam logic [CW-1:0] SYNC_T = CW'(SYNC_RST_CYCLES);
  localparam logic [CW-1:0] RESET_T = CW'(DRAM_RESET_CYCLES);
  localparam logic [CW-1:0] CKE_T = CW'(DRAM_CKE_CYCLES);
  localparam logic [CW-1:0] DRAMSYNC_T = CW'(DRAMSYNC_RST_CYCLES);
  logic rst_int;
  logic [CW-1:0] cnt;
  // state is stored so that all-zero power-up equals the reset state
  logic sync_rel, dramsync_rel, reset_n_q, cke_q;
  crg_reset_sync u_rst_sync (
    .clk(clk100_0__io),
    .arst(rst_0__io),
    .rst_sync(rst_int)
  );
  always_ff @(posedge clk100_0__io or posedge rst_0__io)
    if (rst_0__io) begin
      cnt <= '0;
      sync_rel <= 1'b0;
      dramsync_rel <= 1'b0;
      reset_n_q <= 1'b0;
      cke_q <= 1'b0;
    end else begin
      cnt <= rst_int ? '0 : (cnt == DRAMSYNC_T) ? cnt : cnt + 1'b1;
      sync_rel <= cnt >= SYNC_T;
      reset_n_q <= cnt >= RESET_T;
      cke_q <= cnt >= CKE_T;
      dramsync_rel <= cnt >= DRAMSYNC_T;
    end
  assign crg.crg_sync_clk = clk100_0__io;
  assign crg.crg_dramsync_clk = clk100_0__io;
  assign crg.crg_sync_rst = ~sync_rel;
  assign crg.crg_dramsync_rst = ~dramsync_rel;
  assign crg.dram_reset_n = reset_n_q;
  assign crg.dram_cke = cke_q;
  assign crg.init_done = dramsync_rel;
endmodule

// File: tb/tb_gram_crg.sv
// tb_gram_crg: scoreboard bench; a scaled instance exercises resets, a default instance checks real timing
module tb_gram_crg;
  typedef struct {int cyc; logic [4:0] v;} ev_t;
  logic clk = 1'b0;
  logic rst_s = 1'b0;
  logic rst_d = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  time t_fall = 0;
  ev_t q_s[$];
  ev_t q_d[$];
  logic [4:0] prev_s = 5'b11000;
  logic [4:0] prev_d = 5'b11000;
  logic [4:0] vs, vd;
  gram_crg_if is ();
  gram_crg_if id ();
  gram_crg #(
    .SYNC_RST_CYCLES(4),
    .DRAM_RESET_CYCLES(20),
    .DRAM_CKE_CYCLES(50),
    .DRAMSYNC_RST_CYCLES(64),
    .CNT_WIDTH(7)
  ) u_s (
    .clk100_0__io(clk),
    .rst_0__io(rst_s),
    .crg(is.master)
  );
  gram_crg u_d (
    .clk100_0__io(clk),
    .rst_0__io(rst_d),
    .crg(id.master)
  );
  assign vs = {is.crg_sync_rst, is.crg_dramsync_rst, is.dram_reset_n, is.dram_cke, is.init_done};
  assign vd = {id.crg_sync_rst, id.crg_dramsync_rst, id.dram_reset_n, id.dram_cke, id.init_done};
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic push_s(input int c, input logic [4:0] v);
    q_s.push_back('{c, v});
  endtask
  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask
  always @(negedge clk) begin
    ev_t e;
    if (vs !== prev_s) begin
      checks++;
      if (q_s.size() == 0) begin
        errors++;
        $display("FAIL s_unexpected cyc=%0d got=%b", cyc, vs);
      end else begin
        e = q_s.pop_front();
        if (e.cyc != cyc || e.v !== vs) begin
          errors++;
          $display("FAIL s_event got cyc=%0d %b required cyc=%0d %b", cyc, vs, e.cyc, e.v);
        end
      end
      prev_s = vs;
    end
  end
  always @(negedge clk) begin
    ev_t e;
    if (vd !== prev_d) begin
      if (prev_d[3] && !vd[3]) t_fall = $time;
      checks++;
      if (q_d.size() == 0) begin
        errors++;
        $display("FAIL d_unexpected cyc=%0d got=%b", cyc, vd);
      end else begin
        e = q_d.pop_front();
        if (e.cyc != cyc || e.v !== vd) begin
          errors++;
          $display("FAIL d_event got cyc=%0d %b required cyc=%0d %b", cyc, vd, e.cyc, e.v);
        end
      end
      prev_d = vd;
    end
  end
  initial begin
    #1;
    chk("s_t0", 32'(vs), 32'(5'b11000));
    chk("d_t0", 32'(vd), 32'(5'b11000));
    q_d.push_back('{19, 5'b01000});
    q_d.push_back('{20003, 5'b01100});
    q_d.push_back('{50003, 5'b01110});
    q_d.push_back('{65539, 5'b00111});
    push_s(7, 5'b01000);
    push_s(23, 5'b01100);
    push_s(53, 5'b01110);
    push_s(67, 5'b00111);
    goto(1);
    chk("clk_pass", 32'({is.crg_sync_clk, is.crg_dramsync_clk, id.crg_sync_clk}), 32'(3'b111));
    goto(110);
    push_s(110, 5'b11000);
    rst_s = 1'b1;
    #1;
    chk("s_pulse_immediate", 32'(vs), 32'(5'b11000));
    goto(113);
    push_s(120, 5'b01000);
    push_s(136, 5'b01100);
    push_s(166, 5'b01110);
    push_s(180, 5'b00111);
    rst_s = 1'b0;
    goto(150);
    q_s.delete();
    push_s(150, 5'b11000);
    push_s(157, 5'b01000);
    push_s(173, 5'b01100);
    push_s(203, 5'b01110);
    push_s(217, 5'b00111);
    rst_s = 1'b1;
    #1;
    chk("s_glitch_immediate", 32'(vs), 32'(5'b11000));
    #2;
    rst_s = 1'b0;
    goto(66000);
    chk("s_queue_empty", 32'(q_s.size()), 32'd0);
    chk("d_queue_empty", 32'(q_d.size()), 32'd0);
    chk("s_cnt_saturated", 32'(u_s.cnt), 32'd64);
    chk("d_cnt_saturated", 32'(u_d.cnt), 32'd65536);
    chk("d_fall_window", 32'(t_fall > 600000 && t_fall < 700000), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
